// File: rtl/cache_way_pkg.sv
// Shared types and helpers for one way of the set-associative write-back cache.
// Covers address-split widths, the sequencing state type and the store byte-lane logic.
package cache_way_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_EVICT  = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic int cw_off_w(input int line_words);
        return $clog2(line_words) + 32'sd2;
    endfunction

    function automatic int cw_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int cw_tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - cw_idx_w(sets) - cw_off_w(line_words);
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] boff);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << boff;
            SIZE_HALF: mask = boff[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Right-aligned store data replicated across every lane it could land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{wdata[7:0]}};
            SIZE_HALF: lanes = {2{wdata[15:0]}};
            SIZE_WORD: lanes = wdata;
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/cache_way_ram.sv
// Simple dual-port synchronous RAM with per-lane write enables and one-cycle read latency.
// Contents are not reset; used for both the tag array and the data array.
module cache_way_ram #(
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH  = 1 << AW;
    localparam int LANE_W = DATA_W / BE_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Lane-masked write and registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe[b]) begin
                    mem_r[waddr][b*LANE_W +: LANE_W] <= wdata[b*LANE_W +: LANE_W];
                end
            end
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/cache_way.sv
// One way of a set-associative write-back cache: registered lookup, byte-masked store hits,
// burst line fill and eviction. Hit/miss counters are built only when CACHE_WAY_STATS_EN is defined.
module cache_way #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    input  logic              fill_start,
    input  logic              fill_valid,
    input  logic [31:0]       fill_data,
    input  logic              evict_start,
    input  logic              evict_ready,
    output logic              busy,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_dirty,
    output logic [31:0]       rsp_rdata,
    output logic              fill_done,
    output logic              evict_valid,
    output logic [31:0]       evict_data,
    output logic [ADDR_W-1:0] evict_addr,
    output logic              evict_last,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);
    import cache_way_pkg::*;

    localparam int OFF_W   = cw_off_w(LINE_WORDS);
    localparam int IDX_W   = cw_idx_w(SETS);
    localparam int TAG_W   = cw_tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int WRD_W   = OFF_W - 2;
    localparam int DADDR_W = IDX_W + WRD_W;
    localparam logic [WRD_W-1:0] CNT_LAST = WRD_W'(LINE_WORDS - 1);

    state_e            state_r, state_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic [TAG_W-1:0]  tag_r, tag_nxt_s;
    logic [WRD_W-1:0]  word_r, word_nxt_s;
    logic [1:0]        boff_r, boff_nxt_s;
    logic              we_r, we_nxt_s;
    logic [1:0]        size_r, size_nxt_s;
    logic [31:0]       wdata_r, wdata_nxt_s;
    logic [WRD_W-1:0]  cnt_r, cnt_nxt_s;
    logic [SETS-1:0]   valid_r, valid_nxt_s;
    logic [SETS-1:0]   dirty_r, dirty_nxt_s;
    logic              pend_r, pend_nxt_s;

    logic              busy_r, busy_nxt_s;
    logic              rsp_valid_r, rsp_valid_nxt_s;
    logic              rsp_hit_r, rsp_hit_nxt_s;
    logic              rsp_dirty_r, rsp_dirty_nxt_s;
    logic [31:0]       rsp_rdata_r, rsp_rdata_nxt_s;
    logic              fill_done_r, fill_done_nxt_s;
    logic              evict_valid_r, evict_valid_nxt_s;
    logic [31:0]       evict_data_r, evict_data_nxt_s;
    logic [ADDR_W-1:0] evict_addr_r, evict_addr_nxt_s;
    logic              evict_last_r, evict_last_nxt_s;

    logic [TAG_W-1:0]   req_tag_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [WRD_W-1:0]   req_word_s;
    logic               hit_s;
    logic               tag_we_s;
    logic [TAG_W-1:0]   tag_rdata_s;
    logic [IDX_W-1:0]   tag_raddr_s;
    logic               data_we_s;
    logic [DADDR_W-1:0] data_waddr_s;
    logic [DADDR_W-1:0] data_raddr_s;
    logic [31:0]        data_wdata_s;
    logic [3:0]         data_be_s;
    logic [31:0]        data_rdata_s;

    assign req_tag_s  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx_s  = req_addr[OFF_W +: IDX_W];
    assign req_word_s = req_addr[2 +: WRD_W];
    assign hit_s      = valid_r[idx_r] & (tag_rdata_s == tag_r);

    cache_way_ram #(.DATA_W(TAG_W), .BE_W(1), .AW(IDX_W)) u_tag_ram (
        .clk   (clk),
        .we    (tag_we_s),
        .waddr (idx_r),
        .wdata (tag_r),
        .wbe   (1'b1),
        .raddr (tag_raddr_s),
        .rdata (tag_rdata_s)
    );

    cache_way_ram #(.DATA_W(32), .BE_W(4), .AW(DADDR_W)) u_data_ram (
        .clk   (clk),
        .we    (data_we_s),
        .waddr (data_waddr_s),
        .wdata (data_wdata_s),
        .wbe   (data_be_s),
        .raddr (data_raddr_s),
        .rdata (data_rdata_s)
    );

    // Next-state, RAM port control and next values of every registered output.
    always_comb begin
        state_nxt_s       = state_r;
        idx_nxt_s         = idx_r;
        tag_nxt_s         = tag_r;
        word_nxt_s        = word_r;
        boff_nxt_s        = boff_r;
        we_nxt_s          = we_r;
        size_nxt_s        = size_r;
        wdata_nxt_s       = wdata_r;
        cnt_nxt_s         = cnt_r;
        valid_nxt_s       = valid_r;
        dirty_nxt_s       = dirty_r;
        pend_nxt_s        = 1'b0;
        rsp_valid_nxt_s   = 1'b0;
        rsp_hit_nxt_s     = 1'b0;
        rsp_dirty_nxt_s   = 1'b0;
        rsp_rdata_nxt_s   = 32'h0000_0000;
        fill_done_nxt_s   = 1'b0;
        evict_valid_nxt_s = evict_valid_r;
        evict_data_nxt_s  = evict_data_r;
        evict_addr_nxt_s  = evict_addr_r;
        evict_last_nxt_s  = evict_last_r;
        tag_we_s          = 1'b0;
        data_we_s         = 1'b0;
        data_waddr_s      = {idx_r, cnt_r};
        data_wdata_s      = fill_data;
        data_be_s         = 4'b0000;

        case (state_r)
            ST_IDLE: begin
                if (evict_start || fill_start || req_valid) begin
                    idx_nxt_s   = req_idx_s;
                    tag_nxt_s   = req_tag_s;
                    word_nxt_s  = req_word_s;
                    boff_nxt_s  = req_addr[1:0];
                    we_nxt_s    = req_we;
                    size_nxt_s  = req_size;
                    wdata_nxt_s = req_wdata;
                    cnt_nxt_s   = {WRD_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
                if (evict_start) begin
                    state_nxt_s = ST_EVICT;
                    pend_nxt_s  = 1'b1;
                end else if (fill_start) begin
                    state_nxt_s            = ST_FILL;
                    valid_nxt_s[req_idx_s] = 1'b0;
                end else if (req_valid) begin
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_nxt_s     = ST_IDLE;
                rsp_valid_nxt_s = 1'b1;
                rsp_hit_nxt_s   = hit_s;
                rsp_dirty_nxt_s = dirty_r[idx_r];
                rsp_rdata_nxt_s = hit_s ? (data_rdata_s >> {boff_r, 3'b000}) : 32'h0000_0000;
                if (we_r && hit_s) begin
                    data_we_s          = 1'b1;
                    data_waddr_s       = {idx_r, word_r};
                    data_be_s          = store_mask(size_r, boff_r);
                    data_wdata_s       = store_lanes(size_r, wdata_r);
                    dirty_nxt_s[idx_r] = 1'b1;
                end else begin
                    data_we_s = 1'b0;
                end
            end
            ST_FILL: begin
                if (fill_valid) begin
                    data_we_s    = 1'b1;
                    data_waddr_s = {idx_r, cnt_r};
                    data_be_s    = 4'b1111;
                    data_wdata_s = fill_data;
                    if (cnt_r == CNT_LAST) begin
                        tag_we_s           = 1'b1;
                        valid_nxt_s[idx_r] = 1'b1;
                        dirty_nxt_s[idx_r] = 1'b0;
                        cnt_nxt_s          = {WRD_W{1'b0}};
                        fill_done_nxt_s    = 1'b1;
                        state_nxt_s        = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + WRD_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_EVICT: begin
                // pend_r marks the cycle in which the RAM output holds word[cnt_r].
                if (pend_r) begin
                    evict_valid_nxt_s = 1'b1;
                    evict_data_nxt_s  = data_rdata_s;
                    evict_addr_nxt_s  = {tag_rdata_s, idx_r, {OFF_W{1'b0}}};
                    evict_last_nxt_s  = (cnt_r == CNT_LAST);
                end else if (evict_valid_r && evict_ready) begin
                    evict_valid_nxt_s = 1'b0;
                    evict_last_nxt_s  = 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        dirty_nxt_s[idx_r] = 1'b0;
                        cnt_nxt_s          = {WRD_W{1'b0}};
                        state_nxt_s        = ST_IDLE;
                    end else begin
                        cnt_nxt_s  = cnt_r + WRD_W'(1);
                        pend_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_EVICT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        tag_raddr_s  = idx_nxt_s;
        data_raddr_s = {idx_nxt_s, (state_nxt_s == ST_LOOKUP) ? word_nxt_s : cnt_nxt_s};
    end

    // State, captured request, line status and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            tag_r         <= {TAG_W{1'b0}};
            word_r        <= {WRD_W{1'b0}};
            boff_r        <= 2'b00;
            we_r          <= 1'b0;
            size_r        <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            cnt_r         <= {WRD_W{1'b0}};
            valid_r       <= {SETS{1'b0}};
            dirty_r       <= {SETS{1'b0}};
            pend_r        <= 1'b0;
            busy_r        <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_hit_r     <= 1'b0;
            rsp_dirty_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            fill_done_r   <= 1'b0;
            evict_valid_r <= 1'b0;
            evict_data_r  <= 32'h0000_0000;
            evict_addr_r  <= {ADDR_W{1'b0}};
            evict_last_r  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            tag_r         <= tag_nxt_s;
            word_r        <= word_nxt_s;
            boff_r        <= boff_nxt_s;
            we_r          <= we_nxt_s;
            size_r        <= size_nxt_s;
            wdata_r       <= wdata_nxt_s;
            cnt_r         <= cnt_nxt_s;
            valid_r       <= valid_nxt_s;
            dirty_r       <= dirty_nxt_s;
            pend_r        <= pend_nxt_s;
            busy_r        <= busy_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_hit_r     <= rsp_hit_nxt_s;
            rsp_dirty_r   <= rsp_dirty_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            fill_done_r   <= fill_done_nxt_s;
            evict_valid_r <= evict_valid_nxt_s;
            evict_data_r  <= evict_data_nxt_s;
            evict_addr_r  <= evict_addr_nxt_s;
            evict_last_r  <= evict_last_nxt_s;
        end
    end

    assign busy        = busy_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_hit     = rsp_hit_r;
    assign rsp_dirty   = rsp_dirty_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign fill_done   = fill_done_r;
    assign evict_valid = evict_valid_r;
    assign evict_data  = evict_data_r;
    assign evict_addr  = evict_addr_r;
    assign evict_last  = evict_last_r;

`ifdef CACHE_WAY_STATS_EN
    logic [31:0] stat_hits_r;
    logic [31:0] stat_misses_r;

    // Saturating lookup hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_r   <= 32'h0000_0000;
            stat_misses_r <= 32'h0000_0000;
        end else if (state_r == ST_LOOKUP) begin
            if (hit_s) begin
                if (stat_hits_r != 32'hFFFF_FFFF) stat_hits_r <= stat_hits_r + 32'd1;
            end else begin
                if (stat_misses_r != 32'hFFFF_FFFF) stat_misses_r <= stat_misses_r + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_r;
    assign stat_misses = stat_misses_r;
`else
    assign stat_hits   = 32'h0000_0000;
    assign stat_misses = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_cache_way.sv
// Directed self-checking bench for cache_way: lookup, fill, store merge, eviction,
// reset abort and start priority. Stat checks follow CACHE_WAY_STATS_EN.
module tb_cache_way;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        fill_start;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        evict_start;
    logic        evict_ready;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        rsp_dirty;
    logic [31:0] rsp_rdata;
    logic        fill_done;
    logic        evict_valid;
    logic [31:0] evict_data;
    logic [31:0] evict_addr;
    logic        evict_last;
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;

    int checks = 0;
    int errors = 0;

    cache_way #(.ADDR_W(32), .SETS(64), .LINE_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .fill_start  (fill_start),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .evict_start (evict_start),
        .evict_ready (evict_ready),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_dirty   (rsp_dirty),
        .rsp_rdata   (rsp_rdata),
        .fill_done   (fill_done),
        .evict_valid (evict_valid),
        .evict_data  (evict_data),
        .evict_addr  (evict_addr),
        .evict_last  (evict_last),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One lookup; returns in the cycle where the response is visible.
    task automatic lookup(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic [31:0] wd);
        req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz; req_wdata = wd;
        step();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_we = 1'b0; req_size = 2'd3; req_wdata = ~wd;
        chk1("lk_busy", busy, 1'b1);
        chk1("lk_early_rsp", rsp_valid, 1'b0);
        step();
        chk1("lk_rsp_valid", rsp_valid, 1'b1);
        chk1("lk_busy_clr", busy, 1'b0);
    endtask

    // Full line fill with a one-cycle gap before word 2; word 0 in the low 32 bits.
    task automatic fill(input logic [31:0] a, input logic [127:0] words);
        fill_start = 1'b1; req_addr = a;
        step();
        fill_start = 1'b0; req_addr = 32'hFFFF_FFFF;
        chk1("fill_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                fill_valid = 1'b0;
                step();
            end
            fill_valid = 1'b1;
            fill_data  = words[i*32 +: 32];
            step();
            if (i < 3) chk1("fill_done_early", fill_done, 1'b0);
        end
        fill_valid = 1'b0;
        chk1("fill_done", fill_done, 1'b1);
        chk1("fill_busy_clr", busy, 1'b0);
        step();
        chk1("fill_done_pulse", fill_done, 1'b0);
    endtask

    // Eviction; optionally raises fill_start and req_valid alongside evict_start.
    task automatic evict(input logic [31:0] a, input logic toggle, input logic all_starts,
                         input logic [127:0] exp_words, input logic [31:0] exp_addr);
        logic [31:0] ev_data [4];
        logic [31:0] ev_addr [4];
        logic        ev_last [4];
        int          ev_n;
        logic        spurious;
        ev_n = 0;
        spurious = 1'b0;
        evict_start = 1'b1; req_addr = a;
        fill_start = all_starts; req_valid = all_starts;
        step();
        evict_start = 1'b0; fill_start = 1'b0; req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
        chk1("ev_busy", busy, 1'b1);
        chk1("ev_valid_entry", evict_valid, 1'b0);
        for (int c = 0; c < 40 && ev_n < 4; c++) begin
            evict_ready = toggle ? (c[0] == 1'b0) : 1'b1;
            if (evict_valid && evict_ready) begin
                ev_data[ev_n] = evict_data;
                ev_addr[ev_n] = evict_addr;
                ev_last[ev_n] = evict_last;
                ev_n++;
            end
            if (fill_done || rsp_valid) spurious = 1'b1;
            step();
        end
        evict_ready = 1'b0;
        chk("ev_count", 32'(ev_n), 32'd4);
        chk1("ev_no_other_activity", spurious, 1'b0);
        for (int i = 0; i < ev_n; i++) begin
            chk("ev_data", ev_data[i], exp_words[i*32 +: 32]);
            chk("ev_addr", ev_addr[i], exp_addr);
            chk1("ev_last", ev_last[i], (i == 3));
        end
        chk1("ev_busy_clr", busy, 1'b0);
        chk1("ev_valid_clr", evict_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'd0;
        req_wdata = 32'h0; fill_start = 1'b0; fill_valid = 1'b0; fill_data = 32'h0;
        evict_start = 1'b0; evict_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_hit", rsp_hit, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("rst_fill_done", fill_done, 1'b0);
        chk1("rst_evict_valid", evict_valid, 1'b0);
        chk1("rst_evict_last", evict_last, 1'b0);
        chk("rst_evict_addr", evict_addr, 32'h0);
        chk("rst_stat_hits", stat_hits, 32'h0);
        chk("rst_stat_misses", stat_misses, 32'h0);

        lookup(32'h0000_1234, 1'b0, 2'd2, 32'h0);
        chk1("cold_hit", rsp_hit, 1'b0);
        chk1("cold_dirty", rsp_dirty, 1'b0);

        fill(32'h0000_1230, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});

        lookup(32'h0000_1238, 1'b0, 2'd2, 32'h0);
        chk1("ld_1238_hit", rsp_hit, 1'b1);
        chk("ld_1238_data", rsp_rdata, 32'h3333_3333);
        chk1("ld_1238_clean", rsp_dirty, 1'b0);

        lookup(32'h0000_1239, 1'b1, 2'd0, 32'h0000_00AB);
        chk1("sb_1239_hit", rsp_hit, 1'b1);
        chk("sb_1239_rdata", rsp_rdata, 32'h0033_3333);

        lookup(32'h0000_1238, 1'b0, 2'd2, 32'h0);
        chk1("ld_merge_hit", rsp_hit, 1'b1);
        chk("ld_merge_data", rsp_rdata, 32'h3333_AB33);
        chk1("ld_merge_dirty", rsp_dirty, 1'b1);

        lookup(32'h0000_123E, 1'b1, 2'd1, 32'h0000_BEEF);
        chk1("sh_123e_hit", rsp_hit, 1'b1);
        chk("sh_123e_rdata", rsp_rdata, 32'h0000_4444);

        lookup(32'h0000_123C, 1'b0, 2'd2, 32'h0);
        chk("ld_123c_data", rsp_rdata, 32'hBEEF_4444);

        lookup(32'h0000_5238, 1'b1, 2'd2, 32'hDEAD_BEEF);
        chk1("st_miss_hit", rsp_hit, 1'b0);
        chk1("st_miss_dirty", rsp_dirty, 1'b1);

        lookup(32'h0000_1238, 1'b0, 2'd2, 32'h0);
        chk("st_miss_nowrite", rsp_rdata, 32'h3333_AB33);
`ifdef CACHE_WAY_STATS_EN
        chk("stat_hits_mid", stat_hits, 32'd6);
        chk("stat_misses_mid", stat_misses, 32'd2);
`else
        chk("stat_hits_off", stat_hits, 32'd0);
        chk("stat_misses_off", stat_misses, 32'd0);
`endif

        evict(32'h0000_1234, 1'b1, 1'b0,
              {32'hBEEF_4444, 32'h3333_AB33, 32'h2222_2222, 32'h1111_1111}, 32'h0000_1230);

        lookup(32'h0000_1238, 1'b0, 2'd2, 32'h0);
        chk1("post_ev_hit", rsp_hit, 1'b1);
        chk1("post_ev_dirty", rsp_dirty, 1'b0);
        chk("post_ev_data", rsp_rdata, 32'h3333_AB33);

        fill_start = 1'b1; req_addr = 32'h0000_1230;
        step();
        fill_start = 1'b0; req_addr = 32'hFFFF_FFFF;
        fill_valid = 1'b1; fill_data = 32'hA0A0_A0A0;
        step();
        fill_data = 32'hB1B1_B1B1;
        step();
        fill_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk("abort_stat_hits", stat_hits, 32'h0);

        lookup(32'h0000_1238, 1'b0, 2'd2, 32'h0);
        chk1("abort_miss", rsp_hit, 1'b0);

        evict(32'h0000_1230, 1'b0, 1'b1,
              {32'hBEEF_4444, 32'h3333_AB33, 32'hB1B1_B1B1, 32'hA0A0_A0A0}, 32'h0000_1230);

        lookup(32'h0000_1238, 1'b0, 2'd2, 32'h0);
        chk1("dropped_fill_miss", rsp_hit, 1'b0);

        fill(32'h0000_1230, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        lookup(32'h0000_1230, 1'b0, 2'd2, 32'h0);
        chk("refill_w0", rsp_rdata, 32'h1111_1111);
        lookup(32'h0000_1234, 1'b0, 2'd2, 32'h0);
        chk("refill_w1", rsp_rdata, 32'h2222_2222);
        lookup(32'h0000_123F, 1'b0, 2'd0, 32'h0);
        chk("refill_w3_b3", rsp_rdata, 32'h0000_0044);
`ifdef CACHE_WAY_STATS_EN
        chk("stat_hits_end", stat_hits, 32'd3);
        chk("stat_misses_end", stat_misses, 32'd2);
`else
        chk("stat_hits_end_off", stat_hits, 32'd0);
        chk("stat_misses_end_off", stat_misses, 32'd0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stat_hits_clr", stat_hits, 32'd0);
        chk("stat_misses_clr", stat_misses, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
